// File: rtl/cache_fill_ctrl_pkg.sv
// Shared state encoding and geometry helpers for the cache miss fill controller.
// The constants below describe the default 16-bit / 2-byte / 8-word geometry.
package cache_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    FILL,
    DONE
  } fill_state_t;

  // Counter width that holds both the block size and the in-flight limit.
  function automatic int unsigned cnt_width(input int unsigned block_words,
                                            input int unsigned max_outstanding);
    int unsigned top;
    top = (block_words > max_outstanding) ? block_words : max_outstanding;
    return $clog2(top + 1);
  endfunction

  localparam int unsigned DEF_WORD_BYTES      = 2;
  localparam int unsigned DEF_BLOCK_WORDS     = 8;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  localparam int unsigned OFF_W = $clog2(DEF_WORD_BYTES * DEF_BLOCK_WORDS);
  localparam int unsigned IDX_W = $clog2(DEF_BLOCK_WORDS);
  localparam int unsigned CNT_W = cnt_width(DEF_BLOCK_WORDS, DEF_MAX_OUTSTANDING);

endpackage

// File: rtl/fill_addr_gen.sv
// Forms base | (idx mod BLOCK_WORDS) * WORD_BYTES; idx is already IDX-wide, so
// the modulo is the natural truncation of the index.
module fill_addr_gen
  import cache_fill_ctrl_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned WORD_BYTES  = 2,
  parameter int unsigned BLOCK_WORDS = 8,
  localparam int unsigned IW         = $clog2(BLOCK_WORDS)
) (
  input  logic [AW-1:0] base,
  input  logic [IW-1:0] idx,
  output logic [AW-1:0] addr
);

  localparam int unsigned BSH = $clog2(WORD_BYTES);

  always_comb begin
    addr = base | (AW'(idx) << BSH);
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss controller: optional dirty-victim write-back, pipelined block fill
// (optionally critical-word-first with wrap), then a single tag-commit cycle.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORD_BYTES      = 2,
  parameter int unsigned BLOCK_WORDS     = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CRIT_FIRST      = 1,
  localparam int unsigned OW             = $clog2(WORD_BYTES * BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_address,
  input  logic              memory_ready,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic [OW-1:0]     fsm_offset,
  output logic              read_data_array,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] memory_address,
  output logic              memory_read_req,
  output logic              memory_write_req,
  output logic              finished
);

  localparam int unsigned BSH = $clog2(WORD_BYTES);
  localparam int unsigned IW  = $clog2(BLOCK_WORDS);
  localparam int unsigned CW  = cnt_width(BLOCK_WORDS, MAX_OUTSTANDING);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OW) - 1);
  localparam logic [CW-1:0]     BW_C     = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0]     MO_C     = CW'(MAX_OUTSTANDING);
  localparam logic [IW-1:0]     LAST_IDX = IW'(BLOCK_WORDS - 1);

  fill_state_t       state;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] victim_base;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     wb_idx;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     received;
  logic [CW-1:0]     outstanding;

  logic              rd_req;
  logic              rd_acc;
  logic              wb_acc;
  logic              rx;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     rx_idx;
  logic [IW-1:0]     off_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic [OW-1:0]     off_val;

  // Responses only count while something is in flight, so stale data after an
  // abort or a spurious strobe can never reach the data array.
  always_comb begin
    rd_req  = (state == FILL) && (issued < BW_C) && (outstanding < MO_C);
    rd_acc  = rd_req && memory_ready;
    wb_acc  = (state == EVICT) && memory_ready;
    rx      = (state == FILL) && memory_data_valid && (outstanding != '0);
    rd_idx  = start_idx + issued[IW-1:0];
    rx_idx  = start_idx + received[IW-1:0];
    off_idx = (state == EVICT) ? wb_idx : rx_idx;
  end

  fill_addr_gen #(
    .AW          (ADDR_W),
    .WORD_BYTES  (WORD_BYTES),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_rd_addr (
    .base (fill_base),
    .idx  (rd_idx),
    .addr (rd_addr)
  );

  fill_addr_gen #(
    .AW          (ADDR_W),
    .WORD_BYTES  (WORD_BYTES),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_wb_addr (
    .base (victim_base),
    .idx  (wb_idx),
    .addr (wb_addr)
  );

  fill_addr_gen #(
    .AW          (OW),
    .WORD_BYTES  (WORD_BYTES),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_offset (
    .base ('0),
    .idx  (off_idx),
    .addr (off_val)
  );

  always_comb begin
    fsm_busy         = (state != IDLE);
    read_data_array  = (state == EVICT);
    memory_write_req = (state == EVICT);
    memory_read_req  = rd_req;
    write_data_array = rx;
    write_tag_array  = (state == DONE);
    finished         = (state == DONE);
    memory_address   = '0;
    if (state == EVICT) begin
      memory_address = wb_addr;
    end else if (rd_req) begin
      memory_address = rd_addr;
    end
    fsm_offset = ((state == EVICT) || rx) ? off_val : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fill_base   <= '0;
      victim_base <= '0;
      start_idx   <= '0;
      wb_idx      <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            fill_base   <= miss_address & ~OFF_MASK;
            victim_base <= victim_address & ~OFF_MASK;
            start_idx   <= (CRIT_FIRST != 0) ? miss_address[BSH +: IW] : '0;
            wb_idx      <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            state       <= victim_dirty ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (wb_acc) begin
            wb_idx <= wb_idx + 1'b1;
            if (wb_idx == LAST_IDX) begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (rd_acc) begin
            issued <= issued + 1'b1;
          end
          if (rx) begin
            received <= received + 1'b1;
          end
          outstanding <= outstanding + CW'(rd_acc) - CW'(rx);
          if (rx && (received == BW_C - 1'b1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: a critical-word-first instance and a
// linear-fill instance share stimulus and a latency-configurable memory model.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        victim_dirty = 1'b0;
  logic [15:0] victim_address = '0;
  logic        memory_ready = 1'b0;
  logic        memory_data_valid = 1'b0;

  logic        busy [2];
  logic        rda  [2];
  logic        wda  [2];
  logic        wta  [2];
  logic        rreq [2];
  logic        wreq [2];
  logic        fin  [2];
  logic [3:0]  off  [2];
  logic [15:0] maddr[2];

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] exp_wr_q [2][$];
  logic [15:0] exp_rd_q [2][$];
  logic [3:0]  exp_off_q[2][$];
  int          tag_cnt[2];
  int          exp_tag[2];

  int due_q[$];
  int cyc       = 0;
  int lat       = 1;
  bit ready_tog = 1'b0;
  bit spur      = 1'b0;
  int outst     = 0;
  int max_outst = 0;
  int busy_cnt  = 0;

  always #5 clk = ~clk;

  // Instance 0: critical-word-first (default); instance 1: linear fill.
  cache_fill_ctrl u_dut_cf (
    .clk (clk), .rst (rst),
    .miss_detected (miss_detected), .miss_address (miss_address),
    .victim_dirty (victim_dirty), .victim_address (victim_address),
    .memory_ready (memory_ready), .memory_data_valid (memory_data_valid),
    .fsm_busy (busy[0]), .fsm_offset (off[0]),
    .read_data_array (rda[0]), .write_data_array (wda[0]),
    .write_tag_array (wta[0]), .memory_address (maddr[0]),
    .memory_read_req (rreq[0]), .memory_write_req (wreq[0]),
    .finished (fin[0])
  );

  cache_fill_ctrl #(.CRIT_FIRST(0)) u_dut_lin (
    .clk (clk), .rst (rst),
    .miss_detected (miss_detected), .miss_address (miss_address),
    .victim_dirty (victim_dirty), .victim_address (victim_address),
    .memory_ready (memory_ready), .memory_data_valid (memory_data_valid),
    .fsm_busy (busy[1]), .fsm_offset (off[1]),
    .read_data_array (rda[1]), .write_data_array (wda[1]),
    .write_tag_array (wta[1]), .memory_address (maddr[1]),
    .memory_read_req (rreq[1]), .memory_write_req (wreq[1]),
    .finished (fin[1])
  );

  // Memory model drives at the falling edge; the scoreboard samples 1 later.
  always @(negedge clk) begin
    logic [15:0] e;
    logic [3:0]  eo;
    cyc = cyc + 1;
    memory_ready      = ready_tog ? ((cyc % 2) == 0) : 1'b1;
    memory_data_valid = spur;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      memory_data_valid = 1'b1;
    end
    #1;
    if (busy[0]) busy_cnt++;
    if (rreq[0] && memory_ready) begin
      due_q.push_back(cyc + lat);
      outst++;
    end
    if (wda[0]) outst--;
    if (outst > max_outst) max_outst = outst;
    if (rst) begin
      checks++;
      if (outst > 4) begin
        errors++;
        $display("FAIL outstanding: got %0d required <= 4", outst);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (wreq[d]) begin
        checks++;
        if (exp_wr_q[d].size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected dut%0d: got addr %h required no write", d, maddr[d]);
        end else begin
          e = exp_wr_q[d][0];
          if (maddr[d] !== e || off[d] !== e[3:0] || rda[d] !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr dut%0d: got addr %h off %h rda %b required %h %h 1",
                     d, maddr[d], off[d], rda[d], e, e[3:0]);
          end
          if (memory_ready) void'(exp_wr_q[d].pop_front());
        end
      end
      if (rreq[d]) begin
        checks++;
        if (exp_rd_q[d].size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected dut%0d: got addr %h required no read", d, maddr[d]);
        end else begin
          e = exp_rd_q[d][0];
          if (maddr[d] !== e) begin
            errors++;
            $display("FAIL rd_addr dut%0d: got %h required %h", d, maddr[d], e);
          end
          if (memory_ready) void'(exp_rd_q[d].pop_front());
        end
      end
      if (!rreq[d] && !wreq[d]) begin
        checks++;
        if (maddr[d] !== 16'h0) begin
          errors++;
          $display("FAIL idle_addr dut%0d: got %h required 0000", d, maddr[d]);
        end
      end
      if (wda[d]) begin
        checks++;
        if (exp_off_q[d].size() == 0) begin
          errors++;
          $display("FAIL wda_unexpected dut%0d: got offset %h required no write", d, off[d]);
        end else begin
          eo = exp_off_q[d].pop_front();
          if (off[d] !== eo) begin
            errors++;
            $display("FAIL fill_offset dut%0d: got %h required %h", d, off[d], eo);
          end
        end
      end
      if (wta[d]) begin
        tag_cnt[d]++;
        checks++;
        if (fin[d] !== 1'b1 || busy[d] !== 1'b1) begin
          errors++;
          $display("FAIL done_flags dut%0d: got fin %b busy %b required 1 1", d, fin[d], busy[d]);
        end
      end
    end
  end

  task automatic push_miss(input logic [15:0] m, input bit dirty, input logic [15:0] v);
    int unsigned start;
    int unsigned idx;
    for (int d = 0; d < 2; d++) begin
      if (dirty) begin
        for (int i = 0; i < 8; i++) exp_wr_q[d].push_back((v & 16'hFFF0) | 16'(i * 2));
      end
      start = (d == 0) ? int'(m[3:1]) : 0;
      for (int i = 0; i < 8; i++) begin
        idx = (start + i) % 8;
        exp_rd_q[d].push_back((m & 16'hFFF0) | 16'(idx * 2));
        exp_off_q[d].push_back(4'(idx * 2));
      end
      exp_tag[d]++;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (!busy[0]) begin
        ok = 1'b1;
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL idle_timeout: got busy after 400 cycles required idle");
  endtask

  task automatic run_miss(input logic [15:0] m, input bit dirty, input logic [15:0] v,
                          input int exp_busy);
    int b0;
    bit ok;
    b0 = busy_cnt;
    @(negedge clk);
    miss_address   = m;
    victim_dirty   = dirty;
    victim_address = v;
    miss_detected  = 1'b1;
    push_miss(m, dirty, v);
    @(negedge clk);
    miss_detected = 1'b0;
    victim_dirty  = 1'b0;
    wait_idle(ok);
    if (ok && exp_busy >= 0) begin
      checks++;
      if (busy_cnt - b0 != exp_busy) begin
        errors++;
        $display("FAIL busy_cycles miss %h: got %0d required %0d", m, busy_cnt - b0, exp_busy);
      end
    end
  endtask

  task automatic end_check(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (exp_wr_q[d].size() != 0 || exp_rd_q[d].size() != 0 || exp_off_q[d].size() != 0) begin
        errors++;
        $display("FAIL %s_drain dut%0d: got wr %0d rd %0d off %0d left required 0 0 0",
                 name, d, exp_wr_q[d].size(), exp_rd_q[d].size(), exp_off_q[d].size());
      end
      checks++;
      if (tag_cnt[d] != exp_tag[d]) begin
        errors++;
        $display("FAIL %s_tags dut%0d: got %0d required %0d", name, d, tag_cnt[d], exp_tag[d]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], rda[d], wda[d], wta[d], rreq[d], wreq[d], fin[d]} !== 7'b0 ||
          off[d] !== 4'h0 || maddr[d] !== 16'h0) begin
        errors++;
        $display("FAIL %s dut%0d: got flags %b off %h addr %h required all 0", name, d,
                 {busy[d], rda[d], wda[d], wta[d], rreq[d], wreq[d], fin[d]}, off[d], maddr[d]);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1 check_outputs_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_miss();
    run_miss(16'h1236, 1'b0, 16'h0000, 10);
    end_check("clean");
  endtask

  task automatic test_dirty_miss();
    run_miss(16'h1230, 1'b1, 16'hA0F4, 18);
    end_check("dirty");
  endtask

  task automatic test_backpressure();
    ready_tog = 1'b1;
    lat = 6;
    run_miss(16'h4C0A, 1'b0, 16'h0000, -1);
    run_miss(16'h77F2, 1'b1, 16'h3302, -1);
    ready_tog = 1'b0;
    max_outst = 0;
    run_miss(16'h9E0E, 1'b0, 16'h0000, -1);
    checks++;
    if (max_outst != 4) begin
      errors++;
      $display("FAIL max_outstanding: got %0d required 4", max_outst);
    end
    lat = 1;
    repeat (8) @(negedge clk);
    end_check("backpressure");
  endtask

  task automatic test_spurious_and_held_miss();
    int  b0;
    bit  ok;
    spur = 1'b1;
    repeat (5) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    b0 = busy_cnt;
    @(negedge clk);
    miss_address  = 16'h2008;
    victim_dirty  = 1'b0;
    miss_detected = 1'b1;
    push_miss(16'h2008, 1'b0, 16'h0000);
    @(negedge clk);
    miss_address   = 16'h5A5C;
    victim_dirty   = 1'b1;
    victim_address = 16'hBEEE;
    push_miss(16'h5A5C, 1'b1, 16'hBEEE);
    wait_idle(ok);
    checks++;
    if (busy_cnt - b0 != 10) begin
      errors++;
      $display("FAIL held_miss_first: got %0d busy cycles required 10", busy_cnt - b0);
    end
    @(negedge clk);
    miss_detected = 1'b0;
    victim_dirty  = 1'b0;
    wait_idle(ok);
    end_check("held_miss");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    miss_address  = 16'h3456;
    victim_dirty  = 1'b0;
    miss_detected = 1'b1;
    push_miss(16'h3456, 1'b0, 16'h0000);
    @(negedge clk);
    miss_detected = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_outputs_zero("abort_outputs");
    for (int d = 0; d < 2; d++) begin
      exp_wr_q[d].delete();
      exp_rd_q[d].delete();
      exp_off_q[d].delete();
      exp_tag[d]--;
    end
    outst = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    end_check("abort");
    run_miss(16'h3456, 1'b0, 16'h0000, 10);
    end_check("after_abort");
  endtask

  initial begin
    tag_cnt[0] = 0; tag_cnt[1] = 0;
    exp_tag[0] = 0; exp_tag[1] = 0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_spurious_and_held_miss();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 required finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
